// File: rtl/fb_pkg.sv
// Shared constants and state encoding for the frame-buffer write arbiter.
// Screen geometry lives here so callers can derive addresses consistently.
package fb_pkg;

  localparam int FB_DEPTH = 307200;
  localparam int FB_AW    = 19;
  localparam int FB_DW    = 8;
  localparam int H_RES    = 640;
  localparam int V_RES    = 480;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } fb_arb_state_t;

endpackage

// File: rtl/fb_write_arbiter_rr_arbiter.sv
// Combinational round-robin picker: the first valid requester found when
// searching from i_ptr upwards, wrapping modulo N.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  i_valid,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [PW-1:0] o_grant_idx,
  output logic          o_any
);

  logic [PW-1:0] w_cand;

  // Walk from the farthest candidate back to i_ptr so the closest one wins.
  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    o_any       = 1'b0;
    w_cand      = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_cand = PW'((int'(i_ptr) + k) % N);
      if (i_valid[w_cand]) begin
        o_grant         = '0;
        o_grant[w_cand] = 1'b1;
        o_grant_idx     = w_cand;
        o_any           = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fb_write_arbiter.sv
// Shares the frame-buffer write port between N pixel engines (round-robin,
// one write per clock) and runs a full-buffer clear sweep on request.
module fb_write_arbiter #(
  parameter int N_ENG    = 4,
  parameter int FB_DEPTH = fb_pkg::FB_DEPTH,
  parameter int AW       = fb_pkg::FB_AW,
  parameter int DW       = fb_pkg::FB_DW
) (
  input  logic                clk_iCLK,
  input  logic                iRST_N,
  input  logic [N_ENG-1:0]    iReq_valid,
  output logic [N_ENG-1:0]    oReq_ready,
  input  logic [N_ENG*AW-1:0] iReq_addr,
  input  logic [N_ENG*DW-1:0] iReq_data,
  input  logic                iClear_req,
  input  logic [DW-1:0]       iFill_data,
  output logic                oBusy,
  output logic                oClear_done,
  output logic                oRange_err,
  output logic [AW-1:0]       oPix_count,
  output logic                oWR_en,
  output logic [AW-1:0]       oADDR,
  output logic [DW-1:0]       oDATA,
  output logic [1:0]          oDbg_state
);

  import fb_pkg::*;

  localparam int              PW       = $clog2(N_ENG);
  localparam logic [AW:0]     DEPTH_X  = (AW + 1)'(FB_DEPTH);
  localparam logic [AW-1:0]   DEPTH_A  = AW'(FB_DEPTH);
  localparam logic [AW-1:0]   LAST_A   = AW'(FB_DEPTH - 1);
  localparam logic [PW-1:0]   LAST_ENG = PW'(N_ENG - 1);

  fb_arb_state_t r_state;
  fb_arb_state_t w_next_state;

  logic [PW-1:0]    r_rr_ptr;
  logic [AW-1:0]    r_clr_addr;
  logic             r_wr_en;
  logic [AW-1:0]    r_addr;
  logic [DW-1:0]    r_data;
  logic [AW-1:0]    r_pix_count;
  logic             r_range_err;

  logic [N_ENG-1:0] w_grant;
  logic [PW-1:0]    w_grant_idx;
  logic             w_any;
  logic [N_ENG-1:0] w_ready;
  logic             w_hs;
  logic [AW-1:0]    w_sel_addr;
  logic [DW-1:0]    w_sel_data;
  logic             w_in_range;
  logic             w_arb_en;
  logic             w_start_clear;
  logic             w_clr_issue;

  rr_arbiter #(
    .N  (N_ENG),
    .PW (PW)
  ) u_rr_arbiter (
    .i_valid     (iReq_valid),
    .i_ptr       (r_rr_ptr),
    .o_grant     (w_grant),
    .o_grant_idx (w_grant_idx),
    .o_any       (w_any)
  );

  // Handshake: engine i's write is taken on a rising edge where
  // iReq_valid[i] & oReq_ready[i]; the engine holds valid/addr/data until then.
  // Ready is at most one-hot and depends only on valid, rr_ptr, iClear_req and state.
  assign w_ready    = (w_arb_en && w_any) ? w_grant : '0;
  assign w_hs       = |w_ready;
  assign w_sel_addr = iReq_addr[w_grant_idx*AW +: AW];
  assign w_sel_data = iReq_data[w_grant_idx*DW +: DW];
  assign w_in_range = ({1'b0, w_sel_addr} < DEPTH_X);

  always_ff @(posedge clk_iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_state <= ARB;
    end else begin
      r_state <= w_next_state;
    end
  end

  // A clear request in ARB pre-empts any grant in that same cycle.
  always_comb begin
    w_next_state  = r_state;
    w_arb_en      = 1'b0;
    w_start_clear = 1'b0;
    w_clr_issue   = 1'b0;
    unique case (r_state)
      ARB: begin
        if (iClear_req) begin
          w_start_clear = 1'b1;
          w_next_state  = CLEAR;
        end else begin
          w_arb_en = 1'b1;
        end
      end
      CLEAR: begin
        w_clr_issue = 1'b1;
        if (r_clr_addr == LAST_A) begin
          w_next_state = DONE;
        end
      end
      DONE: begin
        w_next_state = ARB;
      end
      default: begin
        w_next_state = ARB;
      end
    endcase
  end

  always_ff @(posedge clk_iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_rr_ptr    <= '0;
      r_clr_addr  <= '0;
      r_wr_en     <= 1'b0;
      r_addr      <= '0;
      r_data      <= '0;
      r_pix_count <= '0;
      r_range_err <= 1'b0;
    end else begin
      r_wr_en <= 1'b0;
      if (w_start_clear) begin
        r_clr_addr  <= '0;
        r_pix_count <= '0;
        r_range_err <= 1'b0;
      end else if (w_clr_issue) begin
        r_wr_en    <= 1'b1;
        r_addr     <= r_clr_addr;
        r_data     <= iFill_data;
        r_clr_addr <= r_clr_addr + AW'(1);
      end else if (w_hs) begin
        r_rr_ptr <= (w_grant_idx == LAST_ENG) ? '0 : w_grant_idx + PW'(1);
        if (w_in_range) begin
          r_wr_en <= 1'b1;
          r_addr  <= w_sel_addr;
          r_data  <= w_sel_data;
          if (r_pix_count != DEPTH_A) begin
            r_pix_count <= r_pix_count + AW'(1);
          end
        end else begin
          // Out-of-range writes are swallowed; only the sticky flag records them.
          r_range_err <= 1'b1;
        end
      end
    end
  end

  // Ready is the one combinational output, so it is masked while reset is held.
  assign oReq_ready  = w_ready & {N_ENG{iRST_N}};
  assign oBusy       = (r_state == CLEAR);
  assign oClear_done = (r_state == DONE);
  assign oRange_err  = r_range_err;
  assign oPix_count  = r_pix_count;
  assign oWR_en      = r_wr_en;
  assign oADDR       = r_addr;
  assign oDATA       = r_data;
  assign oDbg_state  = r_state;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Randomized and directed bench for fb_write_arbiter against a cycle-level
// reference model; a reduced FB_DEPTH keeps clear sweeps short.
module tb_fb_write_arbiter;

  localparam int N_ENG    = 4;
  localparam int FB_DEPTH = 200;
  localparam int AW       = 19;
  localparam int DW       = 8;
  localparam int POL_SAME = 0;
  localparam int POL_DROP = 1;
  localparam int POL_RAND = 2;

  // ---------------- clock / reset / DUT ----------------
  logic                clk_iCLK = 1'b0;
  logic                iRST_N;
  logic [N_ENG-1:0]    iReq_valid;
  logic [N_ENG-1:0]    oReq_ready;
  logic [N_ENG*AW-1:0] iReq_addr;
  logic [N_ENG*DW-1:0] iReq_data;
  logic                iClear_req;
  logic [DW-1:0]       iFill_data;
  logic                oBusy;
  logic                oClear_done;
  logic                oRange_err;
  logic [AW-1:0]       oPix_count;
  logic                oWR_en;
  logic [AW-1:0]       oADDR;
  logic [DW-1:0]       oDATA;
  logic [1:0]          oDbg_state;

  always #5 clk_iCLK = ~clk_iCLK;

  fb_write_arbiter #(
    .N_ENG    (N_ENG),
    .FB_DEPTH (FB_DEPTH),
    .AW       (AW),
    .DW       (DW)
  ) dut (
    .clk_iCLK    (clk_iCLK),
    .iRST_N      (iRST_N),
    .iReq_valid  (iReq_valid),
    .oReq_ready  (oReq_ready),
    .iReq_addr   (iReq_addr),
    .iReq_data   (iReq_data),
    .iClear_req  (iClear_req),
    .iFill_data  (iFill_data),
    .oBusy       (oBusy),
    .oClear_done (oClear_done),
    .oRange_err  (oRange_err),
    .oPix_count  (oPix_count),
    .oWR_en      (oWR_en),
    .oADDR       (oADDR),
    .oDATA       (oDATA),
    .oDbg_state  (oDbg_state)
  );

  // ---------------- engine-side stimulus state ----------------
  bit   eng_v [N_ENG];
  int   eng_a [N_ENG];
  int   eng_d [N_ENG];
  int   policy;
  bit   clr_req_b;
  logic [DW-1:0] fill_b;

  // ---------------- reference model + scoreboard ----------------
  logic [AW+DW-1:0] exp_q[$];
  int            m_ptr;
  int            m_clr_left;
  int            m_clr_addr;
  int            m_pix;
  bit            m_err;
  bit            m_wr_pend;
  bit            m_done_now;
  logic [AW-1:0] m_last_addr;
  logic [DW-1:0] m_last_data;
  int            hs_eng;
  int            n_done_seen;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_ptr       = 0;
    m_clr_left  = 0;
    m_clr_addr  = 0;
    m_pix       = 0;
    m_err       = 1'b0;
    m_wr_pend   = 1'b0;
    m_done_now  = 1'b0;
    m_last_addr = '0;
    m_last_data = '0;
    hs_eng      = -1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_bus();
    for (int i = 0; i < N_ENG; i++) begin
      iReq_valid[i]          = eng_v[i];
      iReq_addr[i*AW +: AW]  = AW'(eng_a[i]);
      iReq_data[i*DW +: DW]  = DW'(eng_d[i]);
    end
    iClear_req = clr_req_b;
    iFill_data = fill_b;
  endtask

  task automatic new_req(input int i);
    int sel;
    sel      = $urandom_range(0, 9);
    eng_v[i] = 1'b1;
    if (sel == 0)      eng_a[i] = FB_DEPTH + $urandom_range(0, 3);
    else if (sel <= 2) eng_a[i] = FB_DEPTH - 1 - $urandom_range(0, 2);
    else               eng_a[i] = $urandom_range(0, FB_DEPTH - 1);
    eng_d[i] = $urandom_range(0, 255);
  endtask

  task automatic refresh_engines();
    if (hs_eng >= 0) begin
      if (policy == POL_DROP) eng_v[hs_eng] = 1'b0;
      else if (policy == POL_RAND) begin
        if ($urandom_range(0, 1) == 0) eng_v[hs_eng] = 1'b0;
        else new_req(hs_eng);
      end
    end
    if (policy == POL_RAND) begin
      for (int i = 0; i < N_ENG; i++)
        if (!eng_v[i] && $urandom_range(0, 2) == 0) new_req(i);
    end
  endtask

  // One clock: drive at negedge, check shortly after, advance the model.
  task automatic run_cycle();
    logic [N_ENG-1:0] exp_ready;
    logic [AW+DW-1:0] ent;
    int g;
    @(negedge clk_iCLK);
    drive_bus();
    #1;
    exp_ready = '0;
    g = -1;
    if (m_clr_left == 0 && !m_done_now && !iClear_req) begin
      for (int k = 0; k < N_ENG; k++) begin
        if (g < 0 && eng_v[(m_ptr + k) % N_ENG]) g = (m_ptr + k) % N_ENG;
      end
    end
    if (g >= 0) exp_ready[g] = 1'b1;
    check("ready", oReq_ready, exp_ready);
    check("busy", oBusy, m_clr_left > 0);
    check("clear_done", oClear_done, m_done_now);
    check("wr_en", oWR_en, m_wr_pend);
    if (m_wr_pend) begin
      ent         = exp_q.pop_front();
      m_last_addr = ent[AW+DW-1:DW];
      m_last_data = ent[DW-1:0];
    end
    check("addr", oADDR, m_last_addr);
    check("data", oDATA, m_last_data);
    check("pix_count", oPix_count, m_pix);
    check("range_err", oRange_err, m_err);
    if (oClear_done) n_done_seen++;

    hs_eng    = -1;
    m_wr_pend = 1'b0;
    if (m_clr_left > 0) begin
      exp_q.push_back({AW'(m_clr_addr), iFill_data});
      m_wr_pend = 1'b1;
      m_clr_addr++;
      m_clr_left--;
      m_done_now = (m_clr_left == 0);
    end else if (m_done_now) begin
      m_done_now = 1'b0;
    end else if (iClear_req) begin
      m_clr_left = FB_DEPTH;
      m_clr_addr = 0;
      m_pix      = 0;
      m_err      = 1'b0;
    end else if (g >= 0) begin
      hs_eng = g;
      m_ptr  = (g + 1) % N_ENG;
      if (eng_a[g] < FB_DEPTH) begin
        exp_q.push_back({AW'(eng_a[g]), DW'(eng_d[g])});
        m_wr_pend = 1'b1;
        if (m_pix < FB_DEPTH) m_pix++;
      end else begin
        m_err = 1'b1;
      end
    end
    refresh_engines();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, oReq_ready, 0);
    check({tag, "_wr_en"}, oWR_en, 0);
    check({tag, "_addr"}, oADDR, 0);
    check({tag, "_data"}, oDATA, 0);
    check({tag, "_busy"}, oBusy, 0);
    check({tag, "_done"}, oClear_done, 0);
    check({tag, "_err"}, oRange_err, 0);
    check({tag, "_pix"}, oPix_count, 0);
  endtask

  task automatic wait_clear_done(input string tag, output int n_wr, output int n_grant_cyc);
    bit seen;
    seen        = 1'b0;
    n_wr        = 0;
    n_grant_cyc = 0;
    for (int c = 0; c < FB_DEPTH + 10 && !seen; c++) begin
      run_cycle();
      if (oWR_en) n_wr++;
      if (oReq_ready != '0) n_grant_cyc++;
      if (oClear_done) seen = 1'b1;
    end
    if (!seen) check({tag, "_timeout"}, 0, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    int n_wr;
    int n_gc;
    int pix_snap;
    int done_snap;
    logic [N_ENG-1:0] t1_rdy [5];
    logic [AW-1:0]    t1_adr [5];

    for (int i = 0; i < N_ENG; i++) begin
      eng_v[i] = 1'b0;
      eng_a[i] = 0;
      eng_d[i] = 0;
    end
    policy      = POL_DROP;
    clr_req_b   = 1'b0;
    fill_b      = '0;
    n_done_seen = 0;
    model_reset();
    iRST_N = 1'b0;
    drive_bus();
    repeat (3) @(posedge clk_iCLK);
    @(negedge clk_iCLK);
    #1;
    check_all_zero("rst");
    @(posedge clk_iCLK);
    #1 iRST_N = 1'b1;

    // 1: all engines held valid, addr=10*i, data=i
    for (int i = 0; i < N_ENG; i++) begin
      eng_v[i] = 1'b1;
      eng_a[i] = 10 * i;
      eng_d[i] = i;
    end
    policy = POL_SAME;
    for (int c = 0; c < 5; c++) begin
      run_cycle();
      t1_rdy[c] = oReq_ready;
      t1_adr[c] = oADDR;
    end
    for (int c = 0; c < 5; c++) check("t1_grant", t1_rdy[c], 1 << (c % N_ENG));
    for (int c = 1; c < 5; c++) check("t1_addr", t1_adr[c], 10 * (c - 1));
    check("t1_pix", oPix_count, 4);
    policy = POL_DROP;
    repeat (5) run_cycle();

    // 2: lone engine 2 (addr 5, data 7F), then again with rr_ptr at 3
    eng_v[2] = 1'b1; eng_a[2] = 5; eng_d[2] = 8'h7F;
    run_cycle();
    check("t2_grant_a", oReq_ready, 4'b0100);
    run_cycle();
    eng_v[2] = 1'b1;
    run_cycle();
    check("t2_grant_b", oReq_ready, 4'b0100);
    run_cycle();
    check("t2_wr_en", oWR_en, 1);
    check("t2_addr", oADDR, 5);
    check("t2_data", oDATA, 8'h7F);
    eng_v[0] = 1'b1; eng_a[0] = 1; eng_d[0] = 1;
    eng_v[3] = 1'b1; eng_a[3] = 2; eng_d[3] = 2;
    run_cycle();
    check("t2_ptr3", oReq_ready, 4'b1000);
    repeat (3) run_cycle();

    // 3: out-of-range address is granted, dropped, flagged; last in-range accepted
    pix_snap = m_pix;
    eng_v[1] = 1'b1; eng_a[1] = FB_DEPTH; eng_d[1] = 8'h55;
    run_cycle();
    check("t3_grant", oReq_ready, 4'b0010);
    run_cycle();
    check("t3_no_wr", oWR_en, 0);
    check("t3_err", oRange_err, 1);
    check("t3_pix", oPix_count, pix_snap);
    eng_v[1] = 1'b1; eng_a[1] = FB_DEPTH - 1; eng_d[1] = 8'hA5;
    run_cycle();
    run_cycle();
    check("t3_edge_wr", oWR_en, 1);
    check("t3_edge_addr", oADDR, FB_DEPTH - 1);
    check("t3_sticky", oRange_err, 1);

    // 4: clear pulse while all engines are valid
    for (int i = 0; i < N_ENG; i++) begin
      eng_v[i] = 1'b1; eng_a[i] = 3 * i + 1; eng_d[i] = 8'hC0 + i;
    end
    policy    = POL_SAME;
    clr_req_b = 1'b1;
    fill_b    = 8'h00;
    done_snap = n_done_seen;
    run_cycle();
    check("t4_req_cycle_ready", oReq_ready, 0);
    clr_req_b = 1'b0;
    wait_clear_done("t4", n_wr, n_gc);
    check("t4_wr_count", n_wr, FB_DEPTH);
    check("t4_no_grants", n_gc, 0);
    check("t4_done_once", n_done_seen - done_snap, 1);
    run_cycle();
    check("t4_resume", oReq_ready != '0, 1);
    check("t4_pix0", oPix_count, 0);
    check("t4_err0", oRange_err, 0);
    run_cycle();

    // 5: reset in the middle of a clear sweep
    clr_req_b = 1'b1;
    fill_b    = 8'h3C;
    run_cycle();
    clr_req_b = 1'b0;
    for (int c = 0; c < FB_DEPTH && m_clr_addr < FB_DEPTH / 2; c++) run_cycle();
    check("t5_mid_clear", oBusy, 1);
    done_snap = n_done_seen;
    #2 iRST_N = 1'b0;
    #1;
    check_all_zero("t5_async");
    @(posedge clk_iCLK);
    @(negedge clk_iCLK);
    #1;
    check_all_zero("t5_hold");
    model_reset();
    @(posedge clk_iCLK);
    #1 iRST_N = 1'b1;
    for (int i = 0; i < N_ENG; i++) begin
      eng_v[i] = 1'b1; eng_a[i] = 50 + i; eng_d[i] = i;
    end
    run_cycle();
    check("t5_first_grant", oReq_ready, 4'b0001);
    repeat (FB_DEPTH / 2 + 5) run_cycle();
    check("t5_no_done", n_done_seen - done_snap, 0);
    policy = POL_DROP;
    repeat (6) run_cycle();

    // 6: clear and engine 0 arrive together; engine 0 waits for the sweep
    eng_v[0]  = 1'b1; eng_a[0] = 77; eng_d[0] = 8'h11;
    policy    = POL_SAME;
    clr_req_b = 1'b1;
    fill_b    = 8'hE1;
    run_cycle();
    check("t6_ready0", oReq_ready, 0);
    clr_req_b = 1'b0;
    wait_clear_done("t6", n_wr, n_gc);
    check("t6_wr_count", n_wr, FB_DEPTH);
    run_cycle();
    check("t6_eng0_first", oReq_ready, 4'b0001);
    policy = POL_DROP;
    repeat (3) run_cycle();

    // 7: random traffic with occasional clear requests held a few cycles
    policy = POL_RAND;
    begin
      int hold;
      hold = 0;
      for (int c = 0; c < 3000; c++) begin
        if (hold == 0 && $urandom_range(0, 699) == 0) begin
          hold   = $urandom_range(1, 3);
          fill_b = $urandom_range(0, 255);
        end
        clr_req_b = (hold > 0);
        if (hold > 0) hold--;
        run_cycle();
      end
    end
    clr_req_b = 1'b0;
    policy    = POL_DROP;
    repeat (FB_DEPTH + 10) run_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fb_write_arbiter.md
Name: fb_write_arbiter

Overview:
- Shares the single frame-buffer write port (8-bit colour index, 19-bit address, 640x480 = 307,200 locations) between N pixel engines.
- Uses round-robin arbitration, one write per clock.
- Contains a clear sequencer that sweeps the whole buffer with a fill index, for example between zooms.
- Sits between the engine array and the host-side write port of the VGA display block, on the host clock.

Parameters:
- N_ENG, 4, number of requesting engines (2..8).
- FB_DEPTH, 307200, number of valid pixel addresses (0..FB_DEPTH-1).
- AW, 19, address width.
- DW, 8, data (colour index) width.

Ports:
- clk_iCLK  in  1  host clock; all logic is on its rising edge.
- iRST_N  in  1  asynchronous active-low reset.
- iReq_valid  in  N_ENG  per-engine write request.
- oReq_ready  out  N_ENG  per-engine accept, one-hot or zero.
- iReq_addr  in  N_ENG*AW  packed addresses; engine i occupies [i*AW +: AW].
- iReq_data  in  N_ENG*DW  packed colour indices; engine i occupies [i*DW +: DW].
- iClear_req  in  1  request a full-buffer clear (level, sampled).
- iFill_data  in  DW  index written during a clear.
- oBusy  out  1  high while in CLEAR.
- oClear_done  out  1  one-cycle pulse after the last clear write.
- oRange_err  out  1  sticky; set when an engine write with addr >= FB_DEPTH is accepted.
- oPix_count  out  AW  count of in-range engine writes since the last clear or reset; saturates at FB_DEPTH.
- oWR_en  out  1  frame-buffer write enable.
- oADDR  out  AW  frame-buffer write address.
- oDATA  out  DW  frame-buffer write data.

Behaviour:
- Reset (iRST_N=0, asynchronous):
  - State ARB, rr_ptr=0.
  - All outputs 0, including oReq_ready, oWR_en, oADDR, oDATA, oBusy, oClear_done, oRange_err, oPix_count.
- FSM states: ARB, CLEAR, DONE.
- ARB:
  - Combinational grant: the first i with iReq_valid[i]=1, searching rr_ptr, rr_ptr+1, ... modulo N_ENG.
  - oReq_ready = onehot(grant) only if some valid is high and iClear_req=0; otherwise 0.
  - Handshake occurs when valid[i] & ready[i]. The engine holds valid, addr and data stable until ready. Valid may drop only after a handshake.
  - On a handshake with addr < FB_DEPTH, the next cycle has oWR_en=1, oADDR=addr, oDATA=data (latency 1, registered), and oPix_count increments unless already FB_DEPTH.
  - On a handshake with addr >= FB_DEPTH, the write is dropped (oWR_en=0 next cycle), oRange_err is set to 1, and the count is unchanged.
  - After a handshake, rr_ptr = (grant+1) mod N_ENG. Without a handshake, rr_ptr is unchanged.
  - If iClear_req=1: no handshake this cycle (clear has priority over engines). Go to CLEAR, load clr_addr=0, clear oPix_count and oRange_err.
- CLEAR:
  - oBusy=1, oReq_ready=0.
  - Each cycle: oWR_en=1, oADDR=clr_addr, oDATA=iFill_data (registered, so the write appears one cycle after the address is generated). Then clr_addr++.
  - After issuing address FB_DEPTH-1, go to DONE.
  - iClear_req is ignored during CLEAR; a request held high re-triggers only after DONE.
- DONE:
  - oClear_done=1 for exactly one cycle, oBusy=0, oReq_ready=0, then go to ARB.
  - A level-high iClear_req still present in ARB starts a new clear. Requesters therefore pulse iClear_req, or drop it on oClear_done.
- Clear write count: exactly FB_DEPTH writes, addresses 0..FB_DEPTH-1, contiguous, no gaps or repeats.
- oWR_en is low on every cycle with no issued write; oADDR and oDATA hold their last values.
- Reset mid-CLEAR: immediate return to ARB with all outputs 0. No oClear_done.
- oPix_count is not a frame-completion indicator when engines rewrite pixels; it counts accepted writes only.

Decomposition:
- Shared package fb_pkg holds:
  - Constants FB_DEPTH=307200, FB_AW=19, FB_DW=8, H_RES=640, V_RES=480.
  - Enum typedef fb_arb_state_t {ARB, CLEAR, DONE}.
- One natural sub-module: rr_arbiter.
  - Inputs: valid vector and rr_ptr. Output: one-hot grant plus a grant index.
  - Combinational; instantiated once.
- Counters, FSM and output registers stay in fb_write_arbiter.

Test Plan:
1. Reset, then engines 0..3 all valid with addr=10*i and data=i, held. Required: grants 0,1,2,3,0 on consecutive cycles; oWR_en high from the cycle after the first grant; oADDR sequence 0,10,20,30; oPix_count=4 after 4 writes.
2. Only engine 2 valid (addr=5, data=0x7F) with rr_ptr=3. Required: grant to 2 in the same cycle; next cycle oWR_en=1, oADDR=5, oDATA=0x7F; rr_ptr becomes 3.
3. Engine 1 valid with addr=307200. Required: oReq_ready[1]=1, no oWR_en, oRange_err=1 sticky, oPix_count unchanged.
4. iClear_req pulse with iFill_data=0x00 while engines are valid. Required: no grants for 307,201 cycles; oWR_en high for exactly 307,200 consecutive cycles with addresses 0..307199; oClear_done high for exactly 1 cycle; then arbitration resumes, oPix_count=0 and oRange_err=0.
5. Assert iRST_N=0 while the clear is at address 1000. Required: all outputs 0 asynchronously; no oClear_done; after release, state ARB and engines are granted normally.
6. iClear_req and engine-0 valid in the same cycle. Required: oReq_ready=0 that cycle; clear starts; engine 0 is granted in the first ARB cycle after oClear_done.
